// File: rtl/paddle_smoother_pkg.sv
// paddle_smoother_pkg
//   Shared coordinate constants and types for the paddle position conditioner.
//   Holds the 8-bit coordinate width, the default playable-range bounds and
//   reset position, the fill/run state type and a clamp helper.
package paddle_smoother_pkg;

   localparam int COORD_W = 8;

   localparam logic [COORD_W-1:0] Y_MIN_DEF     = 8'd16;
   localparam logic [COORD_W-1:0] Y_MAX_DEF     = 8'd239;
   localparam logic [COORD_W-1:0] RESET_POS_DEF = 8'd128;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [COORD_W-1:0] clamp_coord(
      input logic [COORD_W-1:0] v,
      input logic [COORD_W-1:0] lo,
      input logic [COORD_W-1:0] hi
   );
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

endpackage

// File: rtl/abs_diff8.sv
// abs_diff8
//   Combinational absolute difference of two 8-bit coordinates.
//   Ports:
//     a, b  in   8  operands
//     d     out  8  |a - b|
module abs_diff8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] d
);

   always_comb begin
      if (a >= b) d = a - b;
      else        d = b - a;
   end

endmodule

// File: rtl/paddle_smoother.sv
// paddle_smoother
//   Conditions raw dual-slope ADC paddle readings: outlier rejection with a
//   one-sample confirmation, moving average over 2^LOG2_DEPTH samples, clamp
//   to [Y_MIN, Y_MAX], and output hysteresis.
//   Ports:
//     clk           in   1  stage clock
//     reset         in   1  synchronous, active-high reset
//     sample        in   8  raw conversion result
//     sample_valid  in   1  strobe qualifying sample
//     pos           out  8  filtered paddle centre
//     pos_valid     out  1  pulse: pos re-evaluated (two edges after accept)
//     filling       out  1  high until the window holds DEPTH accepted samples
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_FILL | window not yet full; every strobed sample is accepted
//   ST_RUN  | window full; samples pass the outlier test before acceptance
module paddle_smoother
   import paddle_smoother_pkg::*;
#(
   parameter int                 LOG2_DEPTH = 2,
   parameter logic [COORD_W-1:0] HYST       = 8'd2,
   parameter logic [COORD_W-1:0] JUMP_MAX   = 8'd48,
   parameter logic [COORD_W-1:0] Y_MIN      = Y_MIN_DEF,
   parameter logic [COORD_W-1:0] Y_MAX      = Y_MAX_DEF,
   parameter logic [COORD_W-1:0] RESET_POS  = RESET_POS_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] sample,
   input  logic               sample_valid,
   output logic [COORD_W-1:0] pos,
   output logic               pos_valid,
   output logic               filling
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SUM_W = COORD_W + LOG2_DEPTH;

   // stage 0 state
   state_t                  state_q;
   logic [LOG2_DEPTH-1:0]   fill_cnt_q;
   logic                    pending_q;
   logic [COORD_W-1:0]      pend_q;
   logic [COORD_W-1:0]      avg_q;

   // stage 1 inputs
   logic                    s1_valid;
   logic                    s1_emit;
   logic                    s1_first;
   logic [COORD_W-1:0]      s1_data;

   // window and running sum
   logic [COORD_W-1:0]      buf_q [DEPTH];
   logic [SUM_W-1:0]        sum_q;
   logic [LOG2_DEPTH-1:0]   wptr_q;

   // stage 2 inputs
   logic                    s2_emit;
   logic                    s2_first;

   logic [COORD_W-1:0]      d_avg;
   logic [COORD_W-1:0]      d_pend;
   logic [COORD_W-1:0]      d_hyst;
   logic [COORD_W-1:0]      avg;
   logic [COORD_W-1:0]      clamped;
   logic                    last_fill;
   logic                    near_avg;
   logic                    near_pend;
   logic                    accept;

   abs_diff8 u_diff_avg  (.a(sample),  .b(avg_q),  .d(d_avg));
   abs_diff8 u_diff_pend (.a(sample),  .b(pend_q), .d(d_pend));
   abs_diff8 u_diff_hyst (.a(clamped), .b(pos),    .d(d_hyst));

   assign avg     = sum_q[SUM_W-1:LOG2_DEPTH];
   assign clamped = clamp_coord(avg, Y_MIN, Y_MAX);

   assign last_fill = (state_q == ST_FILL) && (fill_cnt_q == LOG2_DEPTH'(DEPTH - 1));
   assign near_avg  = (d_avg  <= JUMP_MAX);
   assign near_pend = (d_pend <= JUMP_MAX);

   // A far sample is only believed if it agrees with the previously rejected one.
   always_comb begin
      accept = 1'b0;
      if (sample_valid) begin
         if (state_q == ST_FILL)        accept = 1'b1;
         else if (near_avg)             accept = 1'b1;
         else if (pending_q && near_pend) accept = 1'b1;
      end
   end

   // Stage 0: FSM, outlier decision and pending tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_FILL;
         fill_cnt_q <= '0;
         filling    <= 1'b1;
         pending_q  <= 1'b0;
         pend_q     <= '0;
         s1_valid   <= 1'b0;
         s1_emit    <= 1'b0;
         s1_first   <= 1'b0;
         s1_data    <= '0;
      end else begin
         s1_valid <= accept;
         s1_emit  <= accept && ((state_q == ST_RUN) || last_fill);
         s1_first <= accept && last_fill;
         if (accept) s1_data <= sample;

         if (sample_valid) begin
            case (state_q)
               ST_FILL: begin
                  if (last_fill) begin
                     state_q <= ST_RUN;
                     filling <= 1'b0;
                  end else begin
                     fill_cnt_q <= fill_cnt_q + 1'b1;
                  end
               end
               ST_RUN: begin
                  if (near_avg || (pending_q && near_pend)) begin
                     pending_q <= 1'b0;
                  end else begin
                     pending_q <= 1'b1;
                     pend_q    <= sample;
                  end
               end
               default: state_q <= ST_FILL;
            endcase
         end
      end
   end

   // Stage 1: window write and running sum.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
         sum_q    <= '0;
         wptr_q   <= '0;
         s2_emit  <= 1'b0;
         s2_first <= 1'b0;
      end else begin
         s2_emit  <= s1_valid && s1_emit;
         s2_first <= s1_valid && s1_first;
         if (s1_valid) begin
            sum_q         <= sum_q + SUM_W'(s1_data) - SUM_W'(buf_q[wptr_q]);
            buf_q[wptr_q] <= s1_data;
            wptr_q        <= wptr_q + 1'b1;
         end
      end
   end

   // Stage 2: average, clamp, hysteresis. The first output after fill loads
   // unconditionally so pos leaves RESET_POS even for a small move.
   always_ff @(posedge clk) begin
      if (reset) begin
         pos       <= RESET_POS;
         pos_valid <= 1'b0;
         avg_q     <= '0;
      end else begin
         pos_valid <= s2_emit;
         if (s2_emit) begin
            avg_q <= avg;
            if (s2_first || (d_hyst >= HYST)) pos <= clamped;
         end
      end
   end

endmodule

// File: tb/tb_paddle_smoother.sv
// tb_paddle_smoother
//   Self-checking bench: an event-scheduled reference model (window kept as a
//   queue of accepted samples, outputs scheduled two edges after acceptance)
//   is compared with the DUT on every cycle, plus directed literal checks.
module tb_paddle_smoother;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sample;
   logic       sample_valid;
   logic [7:0] pos;
   logic       pos_valid;
   logic       filling;

   paddle_smoother dut (
      .clk          (clk),
      .reset        (reset),
      .sample       (sample),
      .sample_valid (sample_valid),
      .pos          (pos),
      .pos_valid    (pos_valid),
      .filling      (filling)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int due;
      int avg;
      bit first;
   } ev_t;

   int  m_win[$];
   int  m_fill_cnt;
   bit  m_filling;
   bit  m_pending;
   int  m_pend;
   int  m_avgq;
   int  m_pos;
   bit  m_pv;
   int  m_cyc = 0;
   ev_t m_ev[$];

   int  pv_cnt = 0;
   int  pv_cycles[$];

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic int clampv(input int v);
      if (v < 16)  return 16;
      if (v > 239) return 239;
      return v;
   endfunction

   task automatic model_reset();
      m_win = {0, 0, 0, 0};
      m_fill_cnt = 0;
      m_filling  = 1;
      m_pending  = 0;
      m_pend     = 0;
      m_avgq     = 0;
      m_pos      = 128;
      m_pv       = 0;
      m_ev.delete();
   endtask

   task automatic model_edge(input bit r, input bit v, input int s);
      bit  acc;
      bit  emit;
      bit  first;
      int  sum;
      int  c;
      ev_t e;
      m_cyc++;
      if (r) begin
         model_reset();
         return;
      end
      acc = 0;
      if (v) begin
         if (m_filling) acc = 1;
         else if (absd(s, m_avgq) <= 48) begin
            acc = 1; m_pending = 0;
         end else if (!m_pending) begin
            m_pending = 1; m_pend = s;
         end else if (absd(s, m_pend) <= 48) begin
            acc = 1; m_pending = 0;
         end else begin
            m_pend = s;
         end
      end
      m_pv = 0;
      if (m_ev.size() > 0 && m_ev[0].due == m_cyc) begin
         e = m_ev.pop_front();
         c = clampv(e.avg);
         if (e.first || absd(c, m_pos) >= 2) m_pos = c;
         m_avgq = e.avg;
         m_pv = 1;
      end
      if (acc) begin
         m_win.push_back(s);
         void'(m_win.pop_front());
         sum = 0;
         foreach (m_win[i]) sum += m_win[i];
         emit  = !m_filling;
         first = 0;
         if (m_filling) begin
            m_fill_cnt++;
            if (m_fill_cnt == 4) begin
               m_filling = 0; emit = 1; first = 1;
            end
         end
         if (emit) begin
            e.due = m_cyc + 2; e.avg = sum / 4; e.first = first;
            m_ev.push_back(e);
         end
      end
   endtask

   // One clock: drive, take the edge, advance the model, compare.
   task automatic step(input bit r, input bit v, input int s);
      reset        = r;
      sample_valid = v;
      sample       = v ? 8'(s) : 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      model_edge(r, v, s);
      if (pos_valid) begin
         pv_cnt++;
         pv_cycles.push_back(m_cyc);
      end
      chk("pos_valid", int'(pos_valid), int'(m_pv));
      chk("pos",       int'(pos),       m_pos);
      chk("filling",   int'(filling),   int'(m_filling));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   task automatic fill(input int v);
      step(1, 0, 0);
      step(1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, v);
         idle(4);
      end
   endtask

   int c0;
   int base;
   int s;

   initial begin
      model_reset();
      reset = 1; sample_valid = 0; sample = 0;

      // Reset then fill at one strobe per five cycles.
      step(1, 0, 0);
      step(1, 0, 0);
      chk("rst_pos", int'(pos), 128);
      chk("rst_filling", int'(filling), 1);
      chk("rst_pos_valid", int'(pos_valid), 0);
      c0 = pv_cnt;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 100);
         chk("fill_flag", int'(filling), (i < 3) ? 1 : 0);
         if (i < 3) idle(4);
      end
      step(0, 0, 0);
      chk("fill_pos_before", int'(pos), 128);
      chk("fill_pv_before", int'(pos_valid), 0);
      step(0, 0, 0);
      chk("fill_pos", int'(pos), 100);
      chk("fill_pv", int'(pos_valid), 1);
      idle(2);
      chk("fill_pv_count", pv_cnt - c0, 1);

      // Hysteresis.
      fill(100);
      c0 = pv_cnt;
      step(0, 1, 104); idle(3);
      chk("hyst_hold_pos", int'(pos), 100);
      chk("hyst_hold_pv", pv_cnt - c0, 1);
      step(0, 1, 104); idle(3);
      chk("hyst_move_pos", int'(pos), 102);

      // Outlier rejection and pending clear.
      fill(100);
      c0 = pv_cnt;
      step(0, 1, 200); idle(3);
      chk("outlier_pv", pv_cnt - c0, 0);
      chk("outlier_pos", int'(pos), 100);
      step(0, 1, 100); idle(3);
      chk("outlier_recover_pv", pv_cnt - c0, 1);
      step(0, 1, 200); idle(3);
      chk("outlier_pending_cleared", pv_cnt - c0, 1);

      // Persistent jump.
      fill(100);
      step(0, 1, 200); idle(3);
      step(0, 1, 205); idle(3);
      chk("jump_pos", int'(pos), 126);

      // Clamp.
      fill(0);
      chk("clamp_low", int'(pos), 16);
      fill(250);
      chk("clamp_high", int'(pos), 239);

      // Back-to-back strobes from reset.
      step(1, 0, 0);
      step(1, 0, 0);
      pv_cycles.delete();
      for (int i = 0; i < 8; i++) step(0, 1, 30);
      idle(4);
      chk("b2b_pulses", pv_cycles.size(), 5);
      if (pv_cycles.size() == 5) chk("b2b_consecutive", pv_cycles[4] - pv_cycles[0], 4);

      // Reset one cycle after a strobe flushes the pipeline.
      fill(100);
      c0 = pv_cnt;
      step(0, 1, 120);
      step(1, 0, 0);
      chk("midrst_pos", int'(pos), 128);
      chk("midrst_filling", int'(filling), 1);
      idle(3);
      chk("midrst_no_pv", pv_cnt - c0, 0);

      // Randomized run: jitter around a wandering base, glitches, rare resets.
      step(1, 0, 0);
      base = 120;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0) base = $urandom_range(0, 255);
         s = base + $urandom_range(0, 8) - 4;
         if (s < 0)   s = 0;
         if (s > 255) s = 255;
         if ($urandom_range(0, 19) == 0) s = $urandom_range(0, 255);
         step($urandom_range(0, 599) == 0, $urandom_range(0, 2) != 0, s);
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
